// File: rtl/mips_cpu_hilo_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
// It also provides a helper function for conditional two's-complement negation.
package mips_cpu_hilo_pkg;

  typedef enum logic [2:0] {
    HILO_MULT  = 3'd0,
    HILO_MULTU = 3'd1,
    HILO_DIV   = 3'd2,
    HILO_DIVU  = 3'd3,
    HILO_MTHI  = 3'd4,
    HILO_MTLO  = 3'd5
  } hilo_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } hilo_state_t;

  localparam int DIV_ITERS = 32;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] val);
    return neg ? (~val + 32'd1) : val;
  endfunction

endpackage

// File: rtl/mips_cpu_divider.sv
// Unsigned iterative restoring divider: one quotient bit per cycle, MSB first.
// After DIV_ITERS steps it holds its result until the next load.
module mips_cpu_divider
  import mips_cpu_hilo_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] rem_sh;
  logic [31:0] diff;
  logic        fits;

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    rem_sh = {rem_q, quo_q[31]};
    fits   = (rem_sh >= {1'b0, dvs_q});
    // When the trial subtraction fits, the true difference is below 2^32.
    diff   = rem_sh[31:0] - dvs_q;
    if (load) begin
      quo_d = dividend;
      rem_d = 32'd0;
      dvs_d = divisor;
      cnt_d = 6'd0;
    end else if (cnt_q != 6'(DIV_ITERS)) begin
      if (fits) begin
        rem_d = diff;
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = rem_sh[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 6'(DIV_ITERS);
    else       cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    quo_q <= quo_d;
    rem_q <= rem_d;
    dvs_q <= dvs_d;
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mips_cpu_hilo_unit.sv
// HI/LO register pair with a single-cycle multiplier and 32-step divider.
// busy stays high while a result is pending; done pulses when HI/LO update.
module mips_cpu_hilo_unit
  import mips_cpu_hilo_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  hilo_state_t state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        sgn_q, sgn_d;
  logic        done_q, done_d;

  logic               div_load;
  logic               div_signed_in;
  logic [31:0]        div_dividend, div_divisor;
  logic [31:0]        div_quo, div_rem;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               div_by_zero;

  assign prod_s = $signed({{32{op_a_q[31]}}, op_a_q}) * $signed({{32{op_b_q[31]}}, op_b_q});
  assign prod_u = {32'd0, op_a_q} * {32'd0, op_b_q};

  // The divider only ever sees magnitudes; signs are restored in FIX.
  assign div_signed_in = (op == HILO_DIV);
  assign div_dividend  = neg_if(div_signed_in & rs_val[31], rs_val);
  assign div_divisor   = neg_if(div_signed_in & rt_val[31], rt_val);
  assign div_by_zero   = (op_b_q == 32'd0);

  mips_cpu_divider u_divider (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sgn_d    = sgn_q;
    done_d   = 1'b0;
    div_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            HILO_MULT, HILO_MULTU: begin
              op_a_d  = rs_val;
              op_b_d  = rt_val;
              sgn_d   = (op == HILO_MULT);
              state_d = ST_MUL;
            end
            HILO_DIV, HILO_DIVU: begin
              op_a_d   = rs_val;
              op_b_d   = rt_val;
              sgn_d    = (op == HILO_DIV);
              cnt_d    = 5'd0;
              div_load = 1'b1;
              state_d  = ST_DIV;
            end
            HILO_MTHI: hi_d = rs_val;
            HILO_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        {hi_d, lo_d} = sgn_q ? prod_s : prod_u;
        done_d       = 1'b1;
        state_d      = ST_IDLE;
      end
      ST_DIV: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(DIV_ITERS - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (div_by_zero) begin
          hi_d = op_a_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          lo_d = neg_if(sgn_q & (op_a_q[31] ^ op_b_q[31]), div_quo);
          hi_d = neg_if(sgn_q & op_a_q[31], div_rem);
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      sgn_q   <= sgn_d;
    end
  end

  always_ff @(posedge clk) begin
    op_a_q <= op_a_d;
    op_b_q <= op_b_d;
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_hilo_unit.sv
// Self-checking bench for mips_cpu_hilo_unit: scoreboard of expected HI/LO
// results pushed at issue and popped when done is observed.
module tb_mips_cpu_hilo_unit;
  import mips_cpu_hilo_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mips_cpu_hilo_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    int sa, sb, q, r;
    case (o)
      3'd0: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p;
      end
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        r  = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0;
    repeat (3) @(negedge clk);
    checks++; if (hi !== 32'd0)  begin errors++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'd0); end
    checks++; if (lo !== 32'd0)  begin errors++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'd0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_arith(input string name, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                            input int lat);
    exp_t e;
    int   cyc;
    e.hi = eh; e.lo = el; e.lat = lat;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0;
    wait_idle(cyc);
    e = sb_q.pop_front();
    checks++; if (cyc != e.lat)   begin errors++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, cyc, e.lat); end
    checks++; if (done !== 1'b1)  begin errors++; $display("FAIL %s_done got=%b exp=1", name, done); end
    checks++; if (hi !== e.hi)    begin errors++; $display("FAIL %s_hi got=%h exp=%h", name, hi, e.hi); end
    checks++; if (lo !== e.lo)    begin errors++; $display("FAIL %s_lo got=%h exp=%h", name, lo, e.lo); end
    @(negedge clk);
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL %s_done_pulse got=%b exp=0", name, done); end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    logic [63:0] r;
    for (int i = 0; i < 6; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 2 == 1) ? 32'($urandom_range(1, 20)) : $urandom;
      r = model(o, a, b);
      test_arith("rand", o, a, b, r[63:32], r[31:0], (o < 3'd2) ? 1 : 33);
    end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    start = 1'b1; op = HILO_MTHI; rs_val = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi_hi got=%h exp=%h", hi, 32'hDEAD_BEEF); end
    checks++; if (done !== 1'b0)        begin errors++; $display("FAIL mthi_done got=%b exp=0", done); end
    op = HILO_MTLO; rs_val = 32'h0BAD_F00D;
    @(negedge clk);
    start = 1'b0;
    checks++; if (lo !== 32'h0BAD_F00D) begin errors++; $display("FAIL mtlo_lo got=%h exp=%h", lo, 32'h0BAD_F00D); end
    checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mtlo_hi_hold got=%h exp=%h", hi, 32'hDEAD_BEEF); end
    checks++; if (done !== 1'b0)        begin errors++; $display("FAIL mtlo_done got=%b exp=0", done); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL mtlo_busy got=%b exp=0", busy); end
  endtask

  task automatic test_mtlo_during_div();
    exp_t e;
    int   cyc;
    @(negedge clk);
    start = 1'b1; op = HILO_MTHI; rs_val = 32'h2222_2222;
    @(negedge clk);
    op = HILO_MTLO; rs_val = 32'h1111_1111;
    @(negedge clk);
    e.hi = 32'd1; e.lo = 32'd333; e.lat = 33;
    sb_q.push_back(e);
    op = HILO_DIV; rs_val = 32'd1000; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (cyc == 6) begin
        start = 1'b1; op = HILO_MTLO; rs_val = 32'h5555_5555;
      end else begin
        start = 1'b0;
      end
      if (cyc == 8) begin
        checks++; if (lo !== 32'h1111_1111) begin errors++; $display("FAIL div_lo_hold got=%h exp=%h", lo, 32'h1111_1111); end
        checks++; if (hi !== 32'h2222_2222) begin errors++; $display("FAIL div_hi_hold got=%h exp=%h", hi, 32'h2222_2222); end
      end
      @(negedge clk);
    end
    start = 1'b0;
    e = sb_q.pop_front();
    checks++; if (cyc != e.lat)  begin errors++; $display("FAIL mtlo_in_div_cycles got=%0d exp=%0d", cyc, e.lat); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mtlo_in_div_done got=%b exp=1", done); end
    checks++; if (lo !== e.lo)   begin errors++; $display("FAIL mtlo_in_div_lo got=%h exp=%h", lo, e.lo); end
    checks++; if (hi !== e.hi)   begin errors++; $display("FAIL mtlo_in_div_hi got=%h exp=%h", hi, e.hi); end
  endtask

  task automatic test_reset_abort();
    int cyc;
    bit seen_done;
    @(negedge clk);
    start = 1'b1; op = HILO_DIV; rs_val = 32'd1000; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (hi !== 32'd0)  begin errors++; $display("FAIL abort_hi got=%h exp=%h", hi, 32'd0); end
    checks++; if (lo !== 32'd0)  begin errors++; $display("FAIL abort_lo got=%h exp=%h", lo, 32'd0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen_done = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL abort_done_pulse got=%b exp=0", seen_done); end
    test_arith("mult_after_abort", HILO_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 1);
  endtask

  task automatic test_unused_op();
    @(negedge clk);
    start = 1'b1; op = 3'd6; rs_val = 32'hFFFF_0000; rt_val = 32'h1;
    @(negedge clk);
    op = 3'd7;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL unused_busy got=%b exp=0", busy); end
    checks++; if (hi !== 32'd0)   begin errors++; $display("FAIL unused_hi got=%h exp=%h", hi, 32'd0); end
    checks++; if (lo !== 32'd42)  begin errors++; $display("FAIL unused_lo got=%h exp=%h", lo, 32'd42); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL unused_done got=%b exp=0", done); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    start = 1'b1; op = HILO_MULT; rs_val = 32'd2; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_idle(cyc);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got=%b exp=1", done); end
    checks++; if (lo !== 32'd6)  begin errors++; $display("FAIL b2b_first_lo got=%h exp=%h", lo, 32'd6); end
    start = 1'b1; op = HILO_MULTU; rs_val = 32'd4; rt_val = 32'd5;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy got=%b exp=1", busy); end
    wait_idle(cyc);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got=%b exp=1", done); end
    checks++; if (lo !== 32'd20) begin errors++; $display("FAIL b2b_second_lo got=%h exp=%h", lo, 32'd20); end
    checks++; if (hi !== 32'd0)  begin errors++; $display("FAIL b2b_second_hi got=%h exp=%h", hi, 32'd0); end
  endtask

  initial begin
    test_reset();
    test_arith("mult_neg", HILO_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1);
    test_arith("multu_max", HILO_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1);
    test_arith("div_neg", HILO_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    test_arith("divu_100_7", HILO_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    test_arith("divu_zero", HILO_DIVU, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 33);
    test_arith("div_zero", HILO_DIV, 32'h8765_4321, 32'd0, 32'h8765_4321, 32'hFFFF_FFFF, 33);
    test_arith("div_ovf", HILO_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
    test_arith("div_rs_pos_rt_neg", HILO_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
    test_mthi_mtlo();
    test_mtlo_during_div();
    test_random();
    test_reset_abort();
    test_unused_op();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
